// File: rtl/dbg_pkg.sv
// Shared debug types: controller states, halt causes and a saturating counter helper.
package dbg_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2,
    RESUME = 3'd3,
    STEP   = 3'd4
  } dbg_state_e;

  typedef enum logic [1:0] {
    DBG_CAUSE_NONE    = 2'd0,
    DBG_CAUSE_EBREAK  = 2'd1,
    DBG_CAUSE_HALTREQ = 2'd2,
    DBG_CAUSE_STEP    = 2'd3
  } dbg_cause_e;

  localparam logic [63:0] INSN_BYTES = 64'd4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sys_ops.sv
// System-op decode flags travelling with the instruction in execute.
interface sys_ops;
  logic ebreak_op;
  modport src (output ebreak_op);
  modport dst (input ebreak_op);
endinterface

// File: rtl/dbg_ctrl.sv
// Debug halt controller: halts the pipeline on ebreak, halt request or step completion,
// then resumes or single-steps by redirecting fetch to dpc.
module dbg_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc,
  input  logic        retire_valid,
  sys_ops.dst         sys_ops,
  input  logic        halt_req,
  input  logic        resume_req,
  input  logic        step_req,
  input  logic        dpc_we,
  input  logic [63:0] dpc_wdata,
  output logic        stall,
  output logic        flush,
  output logic        halted,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        resume_ack,
  output logic [63:0] dpc,
  output logic [1:0]  cause,
  output logic [31:0] halt_cycles
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  dbg_state_e  state_r, state_s;
  logic [3:0]  drain_cnt_r, drain_cnt_s;
  logic        step_pend_r, step_pend_s;
  logic [63:0] dpc_s, redirect_pc_s;
  logic [1:0]  cause_s;
  logic [31:0] halt_cycles_s;
  logic        flush_s, stall_s, halted_s, redirect_s;

  // Next-state and next-output computation.
  always_comb begin
    state_s       = state_r;
    drain_cnt_s   = drain_cnt_r;
    step_pend_s   = step_pend_r;
    dpc_s         = dpc;
    cause_s       = cause;
    halt_cycles_s = halt_cycles;
    redirect_pc_s = redirect_pc;
    flush_s       = 1'b0;

    case (state_r)
      RUN: begin
        if (retire_valid && (sys_ops.ebreak_op || halt_req)) begin
          flush_s     = 1'b1;
          state_s     = DRAIN;
          drain_cnt_s = DRAIN_LOAD;
          if (sys_ops.ebreak_op) begin
            dpc_s   = pc;
            cause_s = DBG_CAUSE_EBREAK;
          end else begin
            dpc_s   = pc + INSN_BYTES;
            cause_s = DBG_CAUSE_HALTREQ;
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == 4'd0) begin
          state_s       = HALTED;
          halt_cycles_s = 32'd0;
        end else begin
          drain_cnt_s = drain_cnt_r - 4'd1;
        end
      end
      HALTED: begin
        halt_cycles_s = sat_inc32(halt_cycles);
        // A dpc write defers any resume/step seen in the same cycle.
        if (dpc_we) begin
          dpc_s = dpc_wdata;
        end else if (resume_req || step_req) begin
          state_s       = RESUME;
          step_pend_s   = ~resume_req;
          redirect_pc_s = dpc;
        end else begin
          state_s = HALTED;
        end
      end
      RESUME: begin
        if (step_pend_r) begin
          state_s = STEP;
        end else begin
          state_s = RUN;
          cause_s = DBG_CAUSE_NONE;
        end
        step_pend_s = 1'b0;
      end
      STEP: begin
        if (retire_valid) begin
          flush_s     = 1'b1;
          state_s     = DRAIN;
          drain_cnt_s = DRAIN_LOAD;
          if (sys_ops.ebreak_op) begin
            dpc_s   = pc;
            cause_s = DBG_CAUSE_EBREAK;
          end else begin
            dpc_s   = pc + INSN_BYTES;
            cause_s = DBG_CAUSE_STEP;
          end
        end else begin
          state_s = STEP;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase

    stall_s    = (state_s == DRAIN) || (state_s == HALTED) || (state_s == RESUME);
    halted_s   = (state_s == HALTED);
    redirect_s = (state_s == RESUME);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= RUN;
      drain_cnt_r    <= 4'd0;
      step_pend_r    <= 1'b0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      halted         <= 1'b0;
      redirect_valid <= 1'b0;
      resume_ack     <= 1'b0;
      redirect_pc    <= 64'd0;
      dpc            <= 64'd0;
      cause          <= DBG_CAUSE_NONE;
      halt_cycles    <= 32'd0;
    end else begin
      state_r        <= state_s;
      drain_cnt_r    <= drain_cnt_s;
      step_pend_r    <= step_pend_s;
      stall          <= stall_s;
      flush          <= flush_s;
      halted         <= halted_s;
      redirect_valid <= redirect_s;
      resume_ack     <= redirect_s;
      redirect_pc    <= redirect_pc_s;
      dpc            <= dpc_s;
      cause          <= cause_s;
      halt_cycles    <= halt_cycles_s;
    end
  end

endmodule

// File: tb/tb_dbg_ctrl.sv
// Self-checking bench for dbg_ctrl: directed scenarios plus randomized halt/resume/step rounds
// against a transaction-level model of dpc, cause and halt time.
module tb_dbg_ctrl;
  import dbg_pkg::*;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc = 64'd0;
  logic        retire_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic        step_req = 1'b0;
  logic        dpc_we = 1'b0;
  logic [63:0] dpc_wdata = 64'd0;
  logic        stall, flush, halted, redirect_valid, resume_ack;
  logic [63:0] redirect_pc, dpc;
  logic [1:0]  cause;
  logic [31:0] halt_cycles;

  sys_ops ops ();

  always #5 clk = ~clk;

  dbg_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .retire_valid   (retire_valid),
    .sys_ops        (ops),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .step_req       (step_req),
    .dpc_we         (dpc_we),
    .dpc_wdata      (dpc_wdata),
    .stall          (stall),
    .flush          (flush),
    .halted         (halted),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resume_ack     (resume_ack),
    .dpc            (dpc),
    .cause          (cause),
    .halt_cycles    (halt_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what the debugger should see after each transaction.
  logic [63:0] m_dpc   = 64'd0;
  logic [1:0]  m_cause = 2'd0;
  logic [31:0] m_hc    = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".stall"}, 64'(stall), 64'd0);
    chk({tag, ".flush"}, 64'(flush), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".redir"}, 64'(redirect_valid), 64'd0);
    chk({tag, ".ack"}, 64'(resume_ack), 64'd0);
    chk({tag, ".rpc"}, redirect_pc, 64'd0);
    chk({tag, ".dpc"}, dpc, 64'd0);
    chk({tag, ".cause"}, 64'(cause), 64'd0);
    chk({tag, ".hc"}, 64'(halt_cycles), 64'd0);
  endtask

  // Retire one instruction that triggers a halt, then follow it through drain.
  task automatic trigger(input logic [63:0] tpc, input logic eb, input logic hr, input logic in_step);
    pc = tpc; ops.ebreak_op = eb; halt_req = hr; retire_valid = 1'b1;
    if (eb) begin
      m_dpc = tpc; m_cause = 2'd1;
    end else begin
      m_dpc = tpc + 64'd4; m_cause = in_step ? 2'd3 : 2'd2;
    end
    tick();
    chk("trig.flush", 64'(flush), 64'd1);
    chk("trig.stall", 64'(stall), 64'd1);
    chk("trig.halted", 64'(halted), 64'd0);
    retire_valid = 1'b0; ops.ebreak_op = 1'b0; halt_req = 1'b0;
    for (int i = 1; i < D; i++) begin
      tick();
      chk("drain.halted", 64'(halted), 64'd0);
      chk("drain.flush", 64'(flush), 64'd0);
      chk("drain.stall", 64'(stall), 64'd1);
    end
    tick();
    m_hc = 32'd0;
    chk("halt.halted", 64'(halted), 64'd1);
    chk("halt.dpc", dpc, m_dpc);
    chk("halt.cause", 64'(cause), 64'(m_cause));
    chk("halt.hc0", 64'(halt_cycles), 64'd0);
  endtask

  task automatic hc_step();
    m_hc = (m_hc == 32'hFFFF_FFFF) ? m_hc : m_hc + 32'd1;
  endtask

  task automatic wait_halted(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hc_step();
    end
    chk("wait.hc", 64'(halt_cycles), 64'(m_hc));
    chk("wait.halted", 64'(halted), 64'd1);
  endtask

  task automatic write_dpc(input logic [63:0] v, input logic with_resume);
    dpc_we = 1'b1; dpc_wdata = v; resume_req = with_resume;
    tick();
    dpc_we = 1'b0; m_dpc = v; hc_step();
    chk("wr.dpc", dpc, m_dpc);
    chk("wr.halted", 64'(halted), 64'd1);
    chk("wr.redir", 64'(redirect_valid), 64'd0);
  endtask

  // Leave HALTED by resume and/or step request; resume wins when both are high.
  task automatic leave(input logic rs, input logic st);
    logic to_step;
    to_step = st && !rs;
    resume_req = rs; step_req = st;
    tick();
    chk("res.redir", 64'(redirect_valid), 64'd1);
    chk("res.ack", 64'(resume_ack), 64'd1);
    chk("res.rpc", redirect_pc, m_dpc);
    chk("res.halted", 64'(halted), 64'd0);
    chk("res.stall", 64'(stall), 64'd1);
    resume_req = 1'b0; step_req = 1'b0;
    tick();
    if (!to_step) m_cause = 2'd0;
    chk("run.stall", 64'(stall), 64'd0);
    chk("run.redir", 64'(redirect_valid), 64'd0);
    chk("run.ack", 64'(resume_ack), 64'd0);
    chk("run.cause", 64'(cause), 64'(m_cause));
    chk("run.dpc", dpc, m_dpc);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    ops.ebreak_op = 1'b0;
    #2;
    chk_reset_values("por");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_values("rel");

    // halt_req without a retiring instruction must not trigger
    halt_req = 1'b1; ops.ebreak_op = 1'b1;
    tick(); tick();
    chk("noretire.stall", 64'(stall), 64'd0);
    chk("noretire.flush", 64'(flush), 64'd0);
    halt_req = 1'b0; ops.ebreak_op = 1'b0;

    // ebreak halt, 10 halted cycles, write+resume collision
    trigger(64'h8000_0100, 1'b1, 1'b0, 1'b0);
    wait_halted(10);
    chk("hc10", 64'(halt_cycles), 64'd10);
    write_dpc(64'h2000, 1'b1);
    leave(1'b1, 1'b0);

    // halt_req vs ebreak priority at pc 0x1000
    trigger(64'h1000, 1'b0, 1'b1, 1'b0);
    leave(1'b1, 1'b0);
    trigger(64'h1000, 1'b1, 1'b1, 1'b0);
    leave(1'b1, 1'b1);

    // single step: normal retire, then stepping onto an ebreak
    trigger(64'h40, 1'b0, 1'b1, 1'b0);
    write_dpc(64'h3000, 1'b0);
    leave(1'b0, 1'b1);
    halt_req = 1'b1;
    tick();
    chk("step.ignore_hr", 64'(stall), 64'd0);
    trigger(64'h3000, 1'b0, 1'b1, 1'b1);
    chk("step.dpc", dpc, 64'h3004);
    chk("step.cause", 64'(cause), 64'd3);
    write_dpc(64'h3000, 1'b0);
    leave(1'b0, 1'b1);
    trigger(64'h3000, 1'b1, 1'b0, 1'b1);
    chk("stepeb.cause", 64'(cause), 64'd1);

    // saturation of halt_cycles from a preloaded value
    @(negedge clk);
    force dut.halt_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.halt_cycles;
    m_hc = 32'hFFFF_FFFD;
    wait_halted(1);
    wait_halted(3);
    chk("sat", 64'(halt_cycles), 64'hFFFF_FFFF);
    leave(1'b1, 1'b0);

    // pc+4 wraps at 2^64
    trigger(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b0);
    chk("wrap.dpc", dpc, 64'd0);
    leave(1'b1, 1'b0);

    // async reset mid-DRAIN
    halt_req = 1'b1; retire_valid = 1'b1; pc = 64'h55;
    tick();
    halt_req = 1'b0; retire_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_values("rst_drain");
    tick();
    rst_n = 1'b1;
    m_dpc = 64'd0; m_cause = 2'd0;
    trigger(64'h600, 1'b0, 1'b1, 1'b0);
    chk("rst_drain.cause", 64'(cause), 64'd2);

    // async reset mid-STEP
    leave(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_values("rst_step");
    tick();
    rst_n = 1'b1;
    m_dpc = 64'd0; m_cause = 2'd0;
    trigger(64'h700, 1'b0, 1'b1, 1'b0);
    chk("rst_step.cause", 64'(cause), 64'd2);
    leave(1'b1, 1'b0);

    // randomized rounds
    for (int r = 0; r < 24; r++) begin
      logic rs, st;
      int kind;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        pc = rand64();
        retire_valid = 1'($urandom());
        halt_req = retire_valid ? 1'b0 : 1'($urandom());
        ops.ebreak_op = retire_valid ? 1'b0 : 1'($urandom());
        tick();
        chk("rnd.idle_stall", 64'(stall), 64'd0);
        chk("rnd.idle_flush", 64'(flush), 64'd0);
      end
      retire_valid = 1'b0; halt_req = 1'b0; ops.ebreak_op = 1'b0;
      kind = int'($urandom_range(0, 2));
      trigger(rand64(), kind != 1, kind != 0, 1'b0);
      wait_halted(int'($urandom_range(0, 5)));
      if ($urandom_range(0, 1) == 1) write_dpc(rand64(), 1'($urandom()));
      st = 1'($urandom());
      rs = !st || ($urandom_range(0, 3) == 0);
      leave(rs, st);
      if (st && !rs) begin
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
          halt_req = 1'($urandom());
          tick();
          chk("rnd.step_wait", 64'(stall), 64'd0);
        end
        trigger(rand64(), 1'($urandom()), 1'($urandom()), 1'b1);
        leave(1'b1, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
